cr_had_bkpt_mch: RTL and testbench
==================================

// Module: cr_had_bkpt_mch
// PURPOSE
//  Multi-channel HAD memory breakpoint unit, successor to the single-channel breakpoint block.
//  - Provides NUM_CH independent address comparators.
//  - Each channel has a pass counter (trigger on the Nth qualified hit).
//  - Channels can be chained: channel i arms channel i+1.
//  - Sits in HAD between regs (config) and ctrl.
//  - Raises an IF-stage instruction debug request and a retire-stage data debug request.
// PARAMETERS
//  NUM_CH  4   number of breakpoint channels (1..8)
//  ADDR_W  32  address/PC width
//  MASK_W  8   low address bits maskable per channel
//  CNT_W   8   pass-counter width
// PORTS
//  cpuclk                        in  1             core clock
//  hadrst                        in  1             async reset, active-high
//  regs_bkpt_base                in  NUM_CH*ADDR_W per-channel compare base
//  regs_bkpt_mask                in  NUM_CH*MASK_W per-channel low mask (1=compare bit)
//  regs_bkpt_ctrl                in  NUM_CH*3      per-channel mode, encoding below
//  regs_bkpt_chain               in  NUM_CH        bit i=1: ch i arms ch i+1 (bit NUM_CH-1 ignored)
//  regs_bkpt_cnt                 in  NUM_CH*CNT_W  pass-count load value
//  regs_bkpt_cnt_load            in  NUM_CH        1-cycle load strobe per channel
//  regs_bkpt_hit_clr             in  NUM_CH        clear sticky hit status
//  ifu_had_match_pc              in  ADDR_W        IF-stage PC
//  ifu_had_split_first, ifu_had_chg_flw_inst, ifu_had_fetch_expt_vld, ifu_had_inst_dbg_disable  in 1 each
//  lsu_had_addr                  in  ADDR_W        LSU address
//  lsu_had_addr_vld, lsu_had_ex_cmplt, lsu_had_st  in 1 each
//  iu_had_xx_retire, iu_had_xx_retire_normal, iu_had_xx_mldst, iu_had_expt_vld, iu_had_flush  in 1 each
//  iu_yy_xx_dbgon, had_core_dbg_mode_req  in 1 each
//  bkpt_ctrl_inst_fetch_dbq_req  out 1             instruction breakpoint debug request (comb)
//  bkpt_ctrl_req                 out 1             data breakpoint debug request (comb)
//  bkpt_hit_sts                  out NUM_CH        sticky: channel caused a request
//  bkpt_cnt_val                  out NUM_CH*CNT_W  live pass-counter readback
// BEHAVIOUR
//  - Match per channel: (addr & {ones,mask}) == base. Inst side uses ifu_had_match_pc; data side uses lsu_had_addr.
//  - ctrl encoding: 0 off; 1 any; 2 inst; 3 data; 4 change-flow inst; 5 store; 6 load; 7 reserved (treated as off).
//  - Inst hit: match & mode & split_first & !had_core_dbg_mode_req & armed.
//  - Data occur: (match & lsu_had_addr_vld | vld_latch) & iu_had_xx_retire & mode & armed.
//    - vld_latch is set on match & addr_vld.
//    - vld_latch is cleared on ex_cmplt or flush; clear wins over set.
//  - armed: 1 if chain bit of ch i-1 is 0 (or i=0); otherwise the arm flop.
//    - The arm flop is set by a qualified event of ch i-1 with cnt==0.
//    - It is cleared when ch i requests, or on iu_had_expt_vld.
//  - Qualified event with cnt!=0: cnt decrements by 1, no request. With cnt==0: channel fires.
//  - cnt saturates at 0. cnt_load has priority over decrement in the same cycle.
//  - A fired channel with its chain bit set only arms the next channel; it raises no request and sets no status.
//  - Inst fire raises bkpt_ctrl_inst_fetch_dbq_req, same cycle.
//    - Gated by !ifu_had_fetch_expt_vld, !ifu_had_inst_dbg_disable and !iu_yy_xx_dbgon.
//  - Data fire on iu_had_xx_mldst: sets per-channel pend flop; the request is deferred.
//    - pend is released on the next retire with !mldst.
//    - pend is cleared on request or iu_had_expt_vld.
//  - bkpt_ctrl_req = OR(data fire & !mldst, pend release) & retire_normal & !dbgon. Combinational, 0-cycle latency.
//  - Several channels firing in the same cycle: a single request pulse; every firing channel sets its hit_sts bit.
//  - hit_sts clear and set in the same cycle: set wins.
//  - Reset: all cnt, arm, pend, vld_latch and hit_sts = 0; both request outputs deassert.
//  - Reset mid-pend discards the pending request.
// STRUCTURE
//  - Shared package cr_had_bkpt_pkg holds the ctrl encodings (BKPT_OFF..BKPT_LD) and NUM_CH limits.
//  - Sub-module cr_had_bkpt_ch, generated NUM_CH times, holds compare, mode decode, cnt, pend and latch.
//  - Top level holds arm chaining, request OR-reduction and hit_sts.
// TESTING
//  - ch0 ctrl=2, base=0x1000, mask=0xFF, cnt=0; PC 0x1000 with split_first -> inst dbq_req=1 same cycle; hit_sts=0001.
//  - ch1 ctrl=3, cnt=2; three retiring loads to matching addr -> cnt 2,1,0; bkpt_ctrl_req only on the 3rd retire.
//  - ch0 chain=1 (inst 0x2000), ch1 data store 0x3000: store first -> no req.
//    Then fetch 0x2000 (arms ch1), then store -> req=1, hit_sts=0010, arm cleared.
//  - ctrl=5, mldst store hits -> no req; next normal retire -> req=1.
//    Repeat with iu_had_expt_vld between -> no req.
//  - cnt_load=5 in the same cycle as a qualified hit -> cnt reads 5.
//    Assert hadrst mid-pend -> no req, all status 0.

Source files
------------

// File: rtl/cr_had_bkpt_pkg.sv
// Shared definitions for the multi-channel HAD breakpoint unit: channel mode
// encodings and the supported channel-count range.
package cr_had_bkpt_pkg;

  typedef enum logic [2:0] {
    BKPT_OFF    = 3'd0,
    BKPT_ANY    = 3'd1,
    BKPT_INST   = 3'd2,
    BKPT_DATA   = 3'd3,
    BKPT_CHGFLW = 3'd4,
    BKPT_ST     = 3'd5,
    BKPT_LD     = 3'd6,
    BKPT_RSVD   = 3'd7
  } bkpt_mode_e;

  localparam int NUM_CH_MIN = 1;
  localparam int NUM_CH_MAX = 8;

endpackage

// File: rtl/cr_had_bkpt_mch_if.sv
// Bundle of regs/ifu/lsu/iu inputs and debug-request/status outputs of the
// breakpoint unit; master drives the core side, slave is the breakpoint unit.
interface cr_had_bkpt_mch_if #(
  parameter int NUM_CH = 4,
  parameter int ADDR_W = 32,
  parameter int MASK_W = 8,
  parameter int CNT_W  = 8
);
  logic [NUM_CH*ADDR_W-1:0] regs_bkpt_base;
  logic [NUM_CH*MASK_W-1:0] regs_bkpt_mask;
  logic [NUM_CH*3-1:0]      regs_bkpt_ctrl;
  logic [NUM_CH-1:0]        regs_bkpt_chain;
  logic [NUM_CH*CNT_W-1:0]  regs_bkpt_cnt;
  logic [NUM_CH-1:0]        regs_bkpt_cnt_load;
  logic [NUM_CH-1:0]        regs_bkpt_hit_clr;
  logic [ADDR_W-1:0]        ifu_had_match_pc;
  logic                     ifu_had_split_first;
  logic                     ifu_had_chg_flw_inst;
  logic                     ifu_had_fetch_expt_vld;
  logic                     ifu_had_inst_dbg_disable;
  logic [ADDR_W-1:0]        lsu_had_addr;
  logic                     lsu_had_addr_vld;
  logic                     lsu_had_ex_cmplt;
  logic                     lsu_had_st;
  logic                     iu_had_xx_retire;
  logic                     iu_had_xx_retire_normal;
  logic                     iu_had_xx_mldst;
  logic                     iu_had_expt_vld;
  logic                     iu_had_flush;
  logic                     iu_yy_xx_dbgon;
  logic                     had_core_dbg_mode_req;
  // Both requests are single-cycle combinational pulses with no handshake:
  // ctrl samples them in the cycle they are high and nothing is held for it.
  logic                     bkpt_ctrl_inst_fetch_dbq_req;
  logic                     bkpt_ctrl_req;
  logic [NUM_CH-1:0]        bkpt_hit_sts;
  logic [NUM_CH*CNT_W-1:0]  bkpt_cnt_val;

  modport master (
    output regs_bkpt_base, regs_bkpt_mask, regs_bkpt_ctrl, regs_bkpt_chain,
           regs_bkpt_cnt, regs_bkpt_cnt_load, regs_bkpt_hit_clr,
           ifu_had_match_pc, ifu_had_split_first, ifu_had_chg_flw_inst,
           ifu_had_fetch_expt_vld, ifu_had_inst_dbg_disable,
           lsu_had_addr, lsu_had_addr_vld, lsu_had_ex_cmplt, lsu_had_st,
           iu_had_xx_retire, iu_had_xx_retire_normal, iu_had_xx_mldst,
           iu_had_expt_vld, iu_had_flush, iu_yy_xx_dbgon, had_core_dbg_mode_req,
    input  bkpt_ctrl_inst_fetch_dbq_req, bkpt_ctrl_req, bkpt_hit_sts, bkpt_cnt_val
  );

  modport slave (
    input  regs_bkpt_base, regs_bkpt_mask, regs_bkpt_ctrl, regs_bkpt_chain,
           regs_bkpt_cnt, regs_bkpt_cnt_load, regs_bkpt_hit_clr,
           ifu_had_match_pc, ifu_had_split_first, ifu_had_chg_flw_inst,
           ifu_had_fetch_expt_vld, ifu_had_inst_dbg_disable,
           lsu_had_addr, lsu_had_addr_vld, lsu_had_ex_cmplt, lsu_had_st,
           iu_had_xx_retire, iu_had_xx_retire_normal, iu_had_xx_mldst,
           iu_had_expt_vld, iu_had_flush, iu_yy_xx_dbgon, had_core_dbg_mode_req,
    output bkpt_ctrl_inst_fetch_dbq_req, bkpt_ctrl_req, bkpt_hit_sts, bkpt_cnt_val
  );
endinterface

// File: rtl/cr_had_bkpt_ch.sv
// One breakpoint channel: address compare, mode decode, pass counter,
// data-address valid latch and deferred (multi load/store) request flop.
module cr_had_bkpt_ch
  import cr_had_bkpt_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int MASK_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              cpuclk,
  input  logic              hadrst,
  input  logic [ADDR_W-1:0] base,
  input  logic [MASK_W-1:0] mask,
  input  logic [2:0]        ctrl,
  input  logic [CNT_W-1:0]  cnt_ld_val,
  input  logic              cnt_load,
  input  logic [ADDR_W-1:0] pc,
  input  logic              split_first,
  input  logic              chg_flw,
  input  logic              dbg_mode_req,
  input  logic [ADDR_W-1:0] daddr,
  input  logic              addr_vld,
  input  logic              ex_cmplt,
  input  logic              st,
  input  logic              retire,
  input  logic              mldst,
  input  logic              expt_vld,
  input  logic              flush,
  input  logic              armed,
  input  logic              chained,
  input  logic              inst_gate,
  input  logic              data_gate,
  output logic              fire,
  output logic              inst_req,
  output logic              data_req,
  output logic [CNT_W-1:0]  cnt
);

  localparam logic [ADDR_W-MASK_W-1:0] HI_ONES = '1;

  logic [ADDR_W-1:0] full_mask;
  logic pc_match, data_match, inst_mode, data_mode;
  logic inst_hit, data_occ, qual, cnt_zero, pend, vld_latch, pend_rel, pend_set;

  assign full_mask  = {HI_ONES, mask};
  assign pc_match   = (pc & full_mask) == base;
  assign data_match = (daddr & full_mask) == base;

  always_comb begin
    inst_mode = 1'b0;
    data_mode = 1'b0;
    case (bkpt_mode_e'(ctrl))
      BKPT_ANY:    begin inst_mode = 1'b1; data_mode = 1'b1; end
      BKPT_INST:   inst_mode = 1'b1;
      BKPT_DATA:   data_mode = 1'b1;
      BKPT_CHGFLW: inst_mode = chg_flw;
      BKPT_ST:     data_mode = st;
      BKPT_LD:     data_mode = !st;
      default:     ;
    endcase
  end

  assign inst_hit = pc_match && inst_mode && split_first && !dbg_mode_req && armed;
  // The latch remembers an address match whose retire arrives in a later cycle.
  assign data_occ = ((data_match && addr_vld) || vld_latch) && retire && data_mode && armed;
  assign qual     = inst_hit || data_occ;
  assign cnt_zero = (cnt == '0);
  assign fire     = qual && cnt_zero;

  assign inst_req = inst_hit && cnt_zero && !chained && inst_gate;
  assign pend_rel = pend && retire && !mldst;
  assign pend_set = data_occ && cnt_zero && !chained && mldst;
  assign data_req = ((data_occ && cnt_zero && !chained && !mldst) || pend_rel) && data_gate;

  always_ff @(posedge cpuclk or posedge hadrst) begin
    if (hadrst) begin
      cnt       <= '0;
      pend      <= 1'b0;
      vld_latch <= 1'b0;
    end else begin
      if (cnt_load)
        cnt <= cnt_ld_val;
      else if (qual && !cnt_zero)
        cnt <= cnt - CNT_W'(1);
      if (ex_cmplt || flush)
        vld_latch <= 1'b0;
      else if (data_match && addr_vld)
        vld_latch <= 1'b1;
      if (expt_vld || data_req)
        pend <= 1'b0;
      else if (pend_set)
        pend <= 1'b1;
    end
  end

endmodule

// File: rtl/cr_had_bkpt_mch.sv
// Multi-channel HAD breakpoint unit: channel array, arm chaining between
// neighbouring channels, request OR-reduction and sticky hit status.
module cr_had_bkpt_mch
  import cr_had_bkpt_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int ADDR_W = 32,
  parameter int MASK_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic           cpuclk,
  input  logic           hadrst,
  cr_had_bkpt_mch_if.slave bus
);

  if (NUM_CH < NUM_CH_MIN || NUM_CH > NUM_CH_MAX) begin : g_bad_num_ch
    $error("cr_had_bkpt_mch: NUM_CH out of range");
  end

  // The last channel has no successor, so its chain bit is dropped.
  localparam logic [NUM_CH-1:0] CHAIN_OK = {NUM_CH{1'b1}} >> 1;

  logic [NUM_CH-1:0]       chain_eff, armed, arm_q, arm_set, fire, inst_req, data_req, ch_req;
  logic [NUM_CH-1:0]       hit_sts;
  logic [NUM_CH*CNT_W-1:0] cnt_val;
  logic                    inst_gate, data_gate;

  assign chain_eff = bus.regs_bkpt_chain & CHAIN_OK;
  assign armed     = ~(chain_eff << 1) | arm_q;
  assign arm_set   = (fire & chain_eff) << 1;
  assign ch_req    = inst_req | data_req;
  assign inst_gate = !bus.ifu_had_fetch_expt_vld && !bus.ifu_had_inst_dbg_disable && !bus.iu_yy_xx_dbgon;
  assign data_gate = bus.iu_had_xx_retire_normal && !bus.iu_yy_xx_dbgon;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    cr_had_bkpt_ch #(.ADDR_W(ADDR_W), .MASK_W(MASK_W), .CNT_W(CNT_W)) u_ch (
      .cpuclk       (cpuclk),
      .hadrst       (hadrst),
      .base         (bus.regs_bkpt_base[g*ADDR_W +: ADDR_W]),
      .mask         (bus.regs_bkpt_mask[g*MASK_W +: MASK_W]),
      .ctrl         (bus.regs_bkpt_ctrl[g*3 +: 3]),
      .cnt_ld_val   (bus.regs_bkpt_cnt[g*CNT_W +: CNT_W]),
      .cnt_load     (bus.regs_bkpt_cnt_load[g]),
      .pc           (bus.ifu_had_match_pc),
      .split_first  (bus.ifu_had_split_first),
      .chg_flw      (bus.ifu_had_chg_flw_inst),
      .dbg_mode_req (bus.had_core_dbg_mode_req),
      .daddr        (bus.lsu_had_addr),
      .addr_vld     (bus.lsu_had_addr_vld),
      .ex_cmplt     (bus.lsu_had_ex_cmplt),
      .st           (bus.lsu_had_st),
      .retire       (bus.iu_had_xx_retire),
      .mldst        (bus.iu_had_xx_mldst),
      .expt_vld     (bus.iu_had_expt_vld),
      .flush        (bus.iu_had_flush),
      .armed        (armed[g]),
      .chained      (chain_eff[g]),
      .inst_gate    (inst_gate),
      .data_gate    (data_gate),
      .fire         (fire[g]),
      .inst_req     (inst_req[g]),
      .data_req     (data_req[g]),
      .cnt          (cnt_val[g*CNT_W +: CNT_W])
    );
  end

  always_ff @(posedge cpuclk or posedge hadrst) begin
    if (hadrst) begin
      arm_q   <= '0;
      hit_sts <= '0;
    end else begin
      arm_q   <= (arm_q | arm_set) & ~(ch_req | {NUM_CH{bus.iu_had_expt_vld}});
      hit_sts <= (hit_sts & ~bus.regs_bkpt_hit_clr) | ch_req;
    end
  end

  assign bus.bkpt_ctrl_inst_fetch_dbq_req = |inst_req;
  assign bus.bkpt_ctrl_req                = |data_req;
  assign bus.bkpt_hit_sts                 = hit_sts;
  assign bus.bkpt_cnt_val                 = cnt_val;

endmodule

// File: tb/tb_cr_had_bkpt_mch.sv
// Directed bench for cr_had_bkpt_mch: expected request pairs go through a
// scoreboard queue; status and counter readback are checked against constants.
module tb_cr_had_bkpt_mch;
  localparam int NUM_CH = 4;
  localparam int ADDR_W = 32;
  localparam int MASK_W = 8;
  localparam int CNT_W  = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic [1:0] exp_q[$];

  always #5 clk = ~clk;

  cr_had_bkpt_mch_if #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .MASK_W(MASK_W), .CNT_W(CNT_W)) bus ();

  cr_had_bkpt_mch #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .MASK_W(MASK_W), .CNT_W(CNT_W)) dut (
    .cpuclk (clk),
    .hadrst (rst),
    .bus    (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr_dyn();
    bus.regs_bkpt_cnt_load       = '0;
    bus.regs_bkpt_hit_clr        = '0;
    bus.ifu_had_match_pc         = '0;
    bus.ifu_had_split_first      = 1'b0;
    bus.ifu_had_chg_flw_inst     = 1'b0;
    bus.ifu_had_fetch_expt_vld   = 1'b0;
    bus.ifu_had_inst_dbg_disable = 1'b0;
    bus.lsu_had_addr             = '0;
    bus.lsu_had_addr_vld         = 1'b0;
    bus.lsu_had_ex_cmplt         = 1'b0;
    bus.lsu_had_st               = 1'b0;
    bus.iu_had_xx_retire         = 1'b0;
    bus.iu_had_xx_retire_normal  = 1'b0;
    bus.iu_had_xx_mldst          = 1'b0;
    bus.iu_had_expt_vld          = 1'b0;
    bus.iu_had_flush             = 1'b0;
    bus.iu_yy_xx_dbgon           = 1'b0;
    bus.had_core_dbg_mode_req    = 1'b0;
  endtask

  task automatic clr_cfg();
    bus.regs_bkpt_base  = '0;
    bus.regs_bkpt_mask  = '0;
    bus.regs_bkpt_ctrl  = '0;
    bus.regs_bkpt_chain = '0;
    bus.regs_bkpt_cnt   = '0;
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst = 1'b1;
    clr_cfg();
    clr_dyn();
    @(negedge clk);
    chk({tag, "_rst_hit_sts"}, 32'(bus.bkpt_hit_sts), 32'h0);
    chk({tag, "_rst_cnt"}, bus.bkpt_cnt_val, 32'h0);
    chk({tag, "_rst_req"}, {30'h0, bus.bkpt_ctrl_inst_fetch_dbq_req, bus.bkpt_ctrl_req}, 32'h0);
    rst = 1'b0;
  endtask

  task automatic cfg_ch(input int ch, input logic [2:0] mode, input logic [31:0] base,
                        input logic [7:0] mask);
    bus.regs_bkpt_ctrl[ch*3 +: 3]       = mode;
    bus.regs_bkpt_base[ch*ADDR_W +: ADDR_W] = base;
    bus.regs_bkpt_mask[ch*MASK_W +: MASK_W] = mask;
  endtask

  task automatic load_cnt(input int ch, input logic [7:0] val);
    bus.regs_bkpt_cnt[ch*CNT_W +: CNT_W] = val;
    bus.regs_bkpt_cnt_load[ch] = 1'b1;
  endtask

  task automatic fetch(input logic [31:0] pc);
    bus.ifu_had_match_pc    = pc;
    bus.ifu_had_split_first = 1'b1;
  endtask

  task automatic data_acc(input logic [31:0] addr, input logic st, input logic mldst);
    bus.lsu_had_addr            = addr;
    bus.lsu_had_addr_vld        = 1'b1;
    bus.lsu_had_ex_cmplt        = 1'b1;
    bus.lsu_had_st              = st;
    bus.iu_had_xx_retire        = 1'b1;
    bus.iu_had_xx_retire_normal = 1'b1;
    bus.iu_had_xx_mldst         = mldst;
  endtask

  task automatic retire_only();
    bus.iu_had_xx_retire        = 1'b1;
    bus.iu_had_xx_retire_normal = 1'b1;
  endtask

  // Inputs are already driven; record expectation, sample, then advance one cycle.
  task automatic step(input string tag, input logic ei, input logic ed);
    logic [1:0] e;
    exp_q.push_back({ei, ed});
    #1;
    e = exp_q.pop_front();
    chk(tag, {30'h0, bus.bkpt_ctrl_inst_fetch_dbq_req, bus.bkpt_ctrl_req}, {30'h0, e});
    @(negedge clk);
    clr_dyn();
  endtask

  initial begin
    clr_cfg();
    clr_dyn();

    // Instruction breakpoint, mask, gating, sticky clear
    do_reset("s1");
    cfg_ch(0, 3'd2, 32'h1000, 8'hFF);
    fetch(32'h1000);                      step("s1_inst_hit", 1'b1, 1'b0);
    chk("s1_hit_sts", 32'(bus.bkpt_hit_sts), 32'h1);
    fetch(32'h1004);                      step("s1_pc_miss", 1'b0, 1'b0);
    bus.ifu_had_match_pc = 32'h1000;      step("s1_no_split", 1'b0, 1'b0);
    fetch(32'h1000); bus.iu_yy_xx_dbgon = 1'b1; step("s1_dbgon", 1'b0, 1'b0);
    bus.regs_bkpt_hit_clr = 4'b0001;      step("s1_clr", 1'b0, 1'b0);
    chk("s1_hit_cleared", 32'(bus.bkpt_hit_sts), 32'h0);
    cfg_ch(0, 3'd2, 32'h1000, 8'hF0);
    fetch(32'h1005);                      step("s1_mask_hit", 1'b1, 1'b0);
    fetch(32'h1105);                      step("s1_mask_miss", 1'b0, 1'b0);

    // Pass counter on data channel, then valid latch and flush
    do_reset("s2");
    cfg_ch(1, 3'd3, 32'h4000, 8'hFF);
    load_cnt(1, 8'd2);                    step("s2_load", 1'b0, 1'b0);
    chk("s2_cnt2", 32'(bus.bkpt_cnt_val[15:8]), 32'd2);
    data_acc(32'h4000, 1'b0, 1'b0);       step("s2_ld1", 1'b0, 1'b0);
    chk("s2_cnt1", 32'(bus.bkpt_cnt_val[15:8]), 32'd1);
    data_acc(32'h4000, 1'b0, 1'b0);       step("s2_ld2", 1'b0, 1'b0);
    chk("s2_cnt0", 32'(bus.bkpt_cnt_val[15:8]), 32'd0);
    data_acc(32'h4000, 1'b0, 1'b0);       step("s2_ld3", 1'b0, 1'b1);
    chk("s2_hit_sts", 32'(bus.bkpt_hit_sts), 32'h2);
    chk("s2_cnt_sat", 32'(bus.bkpt_cnt_val[15:8]), 32'd0);
    bus.lsu_had_addr = 32'h4000; bus.lsu_had_addr_vld = 1'b1; step("s2_addr_only", 1'b0, 1'b0);
    retire_only();                        step("s2_latch_retire", 1'b0, 1'b1);
    bus.iu_had_flush = 1'b1;              step("s2_flush", 1'b0, 1'b0);
    retire_only();                        step("s2_after_flush", 1'b0, 1'b0);

    // Chain: inst ch0 arms data store ch1
    do_reset("s3");
    cfg_ch(0, 3'd2, 32'h2000, 8'hFF);
    cfg_ch(1, 3'd5, 32'h3000, 8'hFF);
    bus.regs_bkpt_chain = 4'b0001;
    data_acc(32'h3000, 1'b1, 1'b0);       step("s3_unarmed", 1'b0, 1'b0);
    fetch(32'h2000);                      step("s3_arm", 1'b0, 1'b0);
    chk("s3_no_sts", 32'(bus.bkpt_hit_sts), 32'h0);
    data_acc(32'h3000, 1'b1, 1'b0);       step("s3_armed_st", 1'b0, 1'b1);
    chk("s3_hit_sts", 32'(bus.bkpt_hit_sts), 32'h2);
    data_acc(32'h3000, 1'b1, 1'b0);       step("s3_disarmed", 1'b0, 1'b0);

    // Deferred request on multi load/store
    do_reset("s4");
    cfg_ch(1, 3'd5, 32'h3000, 8'hFF);
    data_acc(32'h3000, 1'b0, 1'b0);       step("s4_load_in_st", 1'b0, 1'b0);
    data_acc(32'h3000, 1'b1, 1'b1);       step("s4_mldst", 1'b0, 1'b0);
    retire_only();                        step("s4_release", 1'b0, 1'b1);
    chk("s4_hit_sts", 32'(bus.bkpt_hit_sts), 32'h2);
    retire_only();                        step("s4_once", 1'b0, 1'b0);
    data_acc(32'h3000, 1'b1, 1'b1);       step("s4_mldst2", 1'b0, 1'b0);
    bus.iu_had_expt_vld = 1'b1;           step("s4_expt", 1'b0, 1'b0);
    retire_only();                        step("s4_discard", 1'b0, 1'b0);

    // Load priority over decrement, reset while pending
    do_reset("s5");
    cfg_ch(1, 3'd3, 32'h4000, 8'hFF);
    load_cnt(1, 8'd3);                    step("s5_load3", 1'b0, 1'b0);
    chk("s5_cnt3", 32'(bus.bkpt_cnt_val[15:8]), 32'd3);
    load_cnt(1, 8'd5); data_acc(32'h4000, 1'b0, 1'b0); step("s5_load_hit", 1'b0, 1'b0);
    chk("s5_cnt5", 32'(bus.bkpt_cnt_val[15:8]), 32'd5);
    cfg_ch(2, 3'd3, 32'h4000, 8'hFF);
    data_acc(32'h4000, 1'b0, 1'b0);       step("s5_ch2_fire", 1'b0, 1'b1);
    chk("s5_hit_sts", 32'(bus.bkpt_hit_sts), 32'h4);
    chk("s5_cnt4", 32'(bus.bkpt_cnt_val[15:8]), 32'd4);
    data_acc(32'h4000, 1'b0, 1'b1);       step("s5_pend", 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    chk("s5_rst_sts", 32'(bus.bkpt_hit_sts), 32'h0);
    chk("s5_rst_cnt", bus.bkpt_cnt_val, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    retire_only();                        step("s5_pend_gone", 1'b0, 0);

    // Several channels in one cycle, set-over-clear, fetch exception gate
    do_reset("s6");
    cfg_ch(0, 3'd2, 32'h5000, 8'hFF);
    cfg_ch(2, 3'd1, 32'h5000, 8'hFF);
    cfg_ch(3, 3'd4, 32'h5000, 8'hFF);
    fetch(32'h5000);                      step("s6_multi", 1'b1, 1'b0);
    chk("s6_sts_0101", 32'(bus.bkpt_hit_sts), 32'h5);
    fetch(32'h5000); bus.regs_bkpt_hit_clr = 4'b1111; step("s6_set_wins", 1'b1, 1'b0);
    chk("s6_sts_kept", 32'(bus.bkpt_hit_sts), 32'h5);
    fetch(32'h5000); bus.ifu_had_chg_flw_inst = 1'b1; step("s6_chgflw", 1'b1, 1'b0);
    chk("s6_sts_1101", 32'(bus.bkpt_hit_sts), 32'hD);
    bus.regs_bkpt_hit_clr = 4'b1111;      step("s6_clr_all", 1'b0, 1'b0);
    fetch(32'h5000); bus.ifu_had_fetch_expt_vld = 1'b1; step("s6_fetch_expt", 1'b0, 1'b0);
    chk("s6_sts_zero", 32'(bus.bkpt_hit_sts), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
